// File: rtl/keypad_scanner_pkg.sv
// Shared FSM states, idle-row constant and hex key map for the keypad scanner.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] ROW_NONE = 4'b1111;

  // Board legend: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: 0 F E D
  function automatic logic [3:0] kp_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'h0;
      4'hD: code = 4'hF;
      4'hE: code = 4'hE;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_scan_tick_gen.sv
// Free-running divider: 1-clk tick on the last clk of every CLK_XTAL/CLK_SCAN period.
// Latency: first tick on clk PERIOD after reset; no backpressure, tick is never held off.
module scan_tick_gen #(
  parameter int CLK_XTAL = 50000000,
  parameter int CLK_SCAN = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int PERIOD = CLK_XTAL / CLK_SCAN;
  localparam int W      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: synced rows, one column per tick, debounced press/release, last-4-key register.
// Latency: DEBOUNCE_SCANS-1 ticks after first stable sample +1 clk; no backpressure, key_valid is a bare pulse.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int CLK_XTAL       = 50000000,
  parameter int CLK_SCAN       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] digits
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  logic             scan_tick;
  logic [3:0]       sync_a, sync_b;
  state_t           state, state_nxt;
  logic [1:0]       col, col_nxt;
  logic [1:0]       row_lat, row_lat_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [1:0]       row_act;
  logic             row_hit, row_up;
  logic             accept, release_done;
  logic [3:0]       code;

  scan_tick_gen #(
    .CLK_XTAL (CLK_XTAL),
    .CLK_SCAN (CLK_SCAN)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (scan_tick)
  );

  assign cols    = ~(4'b0001 << col);
  assign cnt_inc = cnt + CNT_W'(1);
  assign row_up  = sync_b[row_lat];
  assign code    = kp_map(row_lat_nxt, col);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= ROW_NONE;
      sync_b <= ROW_NONE;
    end else begin
      sync_a <= rows;
      sync_b <= sync_a;
    end
  end

  // Lowest-index low row wins when several keys share the driven column.
  always_comb begin
    row_hit = (sync_b != ROW_NONE);
    row_act = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!sync_b[r]) row_act = 2'(r);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SCAN;
      col     <= 2'd0;
      row_lat <= 2'd0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      col     <= col_nxt;
      row_lat <= row_lat_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    col_nxt      = col;
    row_lat_nxt  = row_lat;
    cnt_nxt      = cnt;
    accept       = 1'b0;
    release_done = 1'b0;
    if (scan_tick) begin
      case (state)
        SCAN: begin
          if (row_hit) begin
            row_lat_nxt = row_act;
            cnt_nxt     = CNT_W'(1);
            if (DEBOUNCE_SCANS == 1) begin
              state_nxt = PRESSED;
              accept    = 1'b1;
            end else begin
              state_nxt = DEBOUNCE;
            end
          end else begin
            col_nxt = col + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (row_hit && (row_act == row_lat)) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_nxt = PRESSED;
              accept    = 1'b1;
            end
          end else begin
            state_nxt = SCAN;
            col_nxt   = col + 2'd1;
          end
        end
        PRESSED: begin
          if (row_up) begin
            cnt_nxt = CNT_W'(1);
            if (DEBOUNCE_SCANS == 1) begin
              state_nxt    = SCAN;
              release_done = 1'b1;
              col_nxt      = col + 2'd1;
            end else begin
              state_nxt = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (row_up) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_nxt    = SCAN;
              release_done = 1'b1;
              col_nxt      = col + 2'd1;
            end
          end else begin
            state_nxt = PRESSED;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      digits    <= 16'h0000;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= code;
        digits   <= {digits[11:0], code};
        key_held <= 1'b1;
      end else if (release_done) begin
        key_held <= 1'b0;
      end
    end
  end

endmodule
